// File: rtl/serial_word_feeder.sv
// Serialiser feeding the sequence detector: buffers one parallel word and shifts
// words out one bit per clock with a configurable bit order, idle level and gap.
module serial_word_feeder #(
  parameter int WIDTH     = 3,
  parameter int GAP       = 0,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             out,
  output logic             out_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] shifter;
  logic [CW-1:0]    bit_cnt;
  logic [3:0]       gap_cnt;
  logic [WIDTH-1:0] hold_reg;
  logic             hold_full, next_hold_full;

  logic             accept, last_bit, gap_end, reload;
  logic [WIDTH-1:0] load_word;

  // The bit to drive next always sits at the head of the shifter.
  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign din_ready = ~hold_full;

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    accept    = din_valid & ~hold_full;
    last_bit  = (state == S_SHIFT) && (bit_cnt == CW'(WIDTH - 1));
    gap_end   = (state == S_GAP) && (gap_cnt == 4'd0);
    reload    = ((state == S_IDLE) | (last_bit && (GAP == 0)) | gap_end)
                & (hold_full | accept);
    load_word = hold_full ? hold_reg : din;

    if (reload)        next_state = S_SHIFT;
    else if (last_bit) next_state = (GAP > 0) ? S_GAP : S_IDLE;
    else if (gap_end)  next_state = S_IDLE;
    else               next_state = state;

    next_hold_full = hold_full ? ~reload : (accept & ~reload);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      shifter   <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      out       <= IDLE_BIT;
      out_valid <= 1'b0;
      word_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      hold_full <= next_hold_full;
      busy      <= (next_state != S_IDLE) | next_hold_full;
      word_done <= 1'b0;

      if (accept && !reload) hold_reg <= din;

      if (reload) begin
        shifter   <= advance(load_word);
        out       <= head(load_word);
        out_valid <= 1'b1;
        bit_cnt   <= '0;
      end else if ((state == S_SHIFT) && !last_bit) begin
        shifter   <= advance(shifter);
        out       <= head(shifter);
        bit_cnt   <= bit_cnt + 1'b1;
        word_done <= (bit_cnt == CW'(WIDTH - 2));
      end else if (last_bit) begin
        out       <= IDLE_BIT;
        out_valid <= 1'b0;
        if (GAP > 0) gap_cnt <= 4'(GAP - 1);
      end else if (state == S_GAP) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Scoreboard bench: four differently configured feeders; expected bit timing is
// derived from word start = max(accept, previous end + GAP + 1).
module tb_serial_word_feeder;

  localparam int NI = 4;
  localparam int CW [NI] = '{2, 3, 2, 5};
  localparam int CG [NI] = '{0, 0, 2, 1};
  localparam bit CM [NI] = '{1'b1, 1'b1, 1'b0, 1'b0};
  localparam bit CI [NI] = '{1'b0, 1'b0, 1'b1, 1'b0};

  typedef struct { bit b; bit last; int cyc; } exp_bit_t;
  typedef struct { int a; int s; } word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] din       [NI];
  logic        din_valid [NI];
  logic        din_ready [NI];
  logic        out       [NI];
  logic        out_valid [NI];
  logic        word_done [NI];
  logic        busy      [NI];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  exp_bit_t    exp_q  [NI][$];
  word_t       words  [NI][$];
  logic [15:0] send_q [NI][$];
  int          prev_e     [NI];
  int          acc_cnt    [NI];
  int          last_start [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    serial_word_feeder #(
      .WIDTH(CW[gi]), .GAP(CG[gi]), .MSB_FIRST(CM[gi]), .IDLE_BIT(CI[gi])
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .din      (din[gi][CW[gi]-1:0]),
      .din_valid(din_valid[gi]),
      .din_ready(din_ready[gi]),
      .out      (out[gi]),
      .out_valid(out_valid[gi]),
      .word_done(word_done[gi]),
      .busy     (busy[gi])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int inst, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc%0d: got %0d expected %0d", name, inst, cyc, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NI; i++) begin
      exp_q[i].delete();
      words[i].delete();
      send_q[i].delete();
      prev_e[i] = -100;
    end
  endtask

  // Accepted at the coming edge (cyc+1); bits follow back to back from start s.
  task automatic record_accept(input int i, input logic [15:0] w);
    int a, s, wd;
    wd = CW[i];
    a  = cyc + 1;
    s  = (a > prev_e[i] + CG[i] + 1) ? a : prev_e[i] + CG[i] + 1;
    prev_e[i] = s + wd - 1;
    words[i].push_back('{a: a, s: s});
    for (int k = 0; k < wd; k++) begin
      exp_bit_t e;
      e.b    = CM[i] ? w[wd-1-k] : w[k];
      e.last = (k == wd - 1);
      e.cyc  = s + k;
      exp_q[i].push_back(e);
    end
    acc_cnt[i]++;
    last_start[i] = s;
  endtask

  task automatic monitor_inst(input int i);
    int  n;
    bit  exp_ready, exp_busy, exp_valid;
    exp_bit_t e;
    n = cyc;
    exp_ready = 1'b1;
    exp_busy  = 1'b0;
    for (int k = 0; k < words[i].size(); k++) begin
      if (words[i][k].a <= n && n < words[i][k].s) begin
        exp_ready = 1'b0;
        exp_busy  = 1'b1;
      end
      if (words[i][k].s <= n && n <= words[i][k].s + CW[i] - 1 + CG[i]) exp_busy = 1'b1;
    end
    check("din_ready", i, int'(din_ready[i]), int'(exp_ready));
    check("busy", i, int'(busy[i]), int'(exp_busy));

    exp_valid = (exp_q[i].size() > 0) && (exp_q[i][0].cyc == n);
    check("out_valid", i, int'(out_valid[i]), int'(exp_valid));
    if (exp_valid) begin
      e = exp_q[i].pop_front();
      if (out_valid[i]) begin
        check("out_bit", i, int'(out[i]), int'(e.b));
        check("word_done", i, int'(word_done[i]), int'(e.last));
      end
    end else begin
      check("idle_level", i, int'(out[i]), int'(CI[i]));
      check("word_done_idle", i, int'(word_done[i]), 0);
    end

    while (words[i].size() > 0 && words[i][0].s + CW[i] - 1 + CG[i] < n)
      void'(words[i].pop_front());
  endtask

  task automatic check_reset_values(input int i);
    check("rst_out", i, int'(out[i]), int'(CI[i]));
    check("rst_out_valid", i, int'(out_valid[i]), 0);
    check("rst_word_done", i, int'(word_done[i]), 0);
    check("rst_busy", i, int'(busy[i]), 0);
    check("rst_din_ready", i, int'(din_ready[i]), 1);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst) check_reset_values(i);
      else      monitor_inst(i);
    end
  end

  // One cycle of stimulus: each lane presents its next word with probability pct.
  task automatic step(input int pct);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      if (send_q[i].size() > 0 && $urandom_range(99) < pct) begin
        din_valid[i] = 1'b1;
        din[i]       = send_q[i][0];
        if (rst && din_ready[i]) begin
          record_accept(i, send_q[i][0]);
          void'(send_q[i].pop_front());
        end
      end else begin
        din_valid[i] = 1'b0;
        din[i]       = 16'($urandom);
      end
    end
  endtask

  task automatic run_until_sent(input int pct);
    int left, guard;
    guard = 0;
    do begin
      step(pct);
      left = 0;
      for (int i = 0; i < NI; i++) left += send_q[i].size();
      guard++;
    end while (left > 0 && guard < 500);
    check("send_timeout_words_left", 0, left, 0);
  endtask

  task automatic drain();
    int left, guard;
    guard = 0;
    do begin
      step(0);
      left = 0;
      for (int i = 0; i < NI; i++) left += exp_q[i].size();
      guard++;
    end while (left > 0 && guard < 300);
    check("drain_bits_left", 0, left, 0);
    repeat (4) step(0);
  endtask

  function automatic logic [15:0] rand_word(input int i);
    return 16'($urandom) & 16'((1 << CW[i]) - 1);
  endfunction

  initial begin
    int mid_s, base, guard;
    clear_model();
    for (int i = 0; i < NI; i++) begin
      acc_cnt[i]    = 0;
      last_start[i] = 0;
      din_valid[i]  = 1'b1;
      din[i]        = 16'hFFFF;
    end

    // Reset held with valid words offered: nothing may be accepted or emitted.
    repeat (4) @(negedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) din_valid[i] = 1'b0;
    repeat (2) step(0);

    // Directed patterns.
    send_q[0].push_back(16'b10);
    send_q[1].push_back(16'b111);
    send_q[1].push_back(16'b110);
    send_q[2].push_back(16'b10);
    send_q[2].push_back(16'b00);
    send_q[3].push_back(16'b10011);
    send_q[3].push_back(16'b01100);
    run_until_sent(100);
    drain();

    // Backpressure: four words offered with valid held high.
    send_q[0].push_back(16'b01);
    send_q[0].push_back(16'b00);
    send_q[0].push_back(16'b10);
    send_q[0].push_back(16'b11);
    for (int i = 1; i < NI; i++)
      for (int k = 0; k < 4; k++) send_q[i].push_back(rand_word(i));
    run_until_sent(100);
    drain();

    // Random traffic with random valid bubbles, then saturated traffic.
    for (int r = 0; r < 400; r++) begin
      for (int i = 0; i < NI; i++)
        if (send_q[i].size() < 2) send_q[i].push_back(rand_word(i));
      step(r < 250 ? 60 : 100);
    end
    for (int i = 0; i < NI; i++) send_q[i].delete();
    drain();

    // Reset after the second bit of 110 while 101 sits in the holding register.
    send_q[1].push_back(16'b110);
    send_q[1].push_back(16'b101);
    base  = acc_cnt[1];
    guard = 0;
    while (acc_cnt[1] == base && guard < 20) begin
      step(100);
      guard++;
    end
    mid_s = last_start[1];
    guard = 0;
    while (cyc < mid_s + 1 && guard < 20) begin
      step(100);
      guard++;
    end
    check("held_word_present", 1, int'(din_ready[1]), 0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NI; i++) din_valid[i] = 1'b0;
    clear_model();
    #1;
    for (int i = 0; i < NI; i++) check_reset_values(i);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    repeat (20) step(0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_word_feeder.md
# serial_word_feeder

Upstream stage of the serial sequence-detector FSM. Accepts parallel words over a valid/ready handshake, buffers one word, and shifts each word out one bit per clock on a single serial line that drives the detector's `in` input. Bit order, idle level and inter-word gap are parameters, so directed bit patterns (10, 01, 00, 111, 110, ...) can be issued as words instead of being hand-toggled per cycle.

## Interface
- `WIDTH`, default 3: bits per word; legal range 2..16.
- `GAP`, default 0: idle cycles inserted after each word; legal range 0..15.
- `MSB_FIRST`, default 1: 1 = bit `WIDTH-1` first, 0 = bit 0 first.
- `IDLE_BIT`, default 0: level driven on `out` when no bit is being sent.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset: asserting low clears state immediately; deassertion is synchronous to `clk` by the driver.
- `din`  input  WIDTH  parallel word.
- `din_valid`  input  1  `din` is valid.
- `din_ready`  output  1  block can accept a word this cycle.
- `out`  output  1  serial bit, registered; feeds detector `in`.
- `out_valid`  output  1  `out` carries a data bit this cycle.
- `word_done`  output  1  one-cycle pulse coincident with the last bit of a word.
- `busy`  output  1  high when the shifter or holding register is occupied.

## Operation
- Storage: a shift register with its bit counter, plus a one-word holding register with a `hold_full` flag.
- `din_ready = ~hold_full`. A word is accepted on a rising edge when `din_valid & din_ready`. With `rst` low, `din_ready` is 1 but nothing is accepted.
- Accepted word destination:
  - It loads the shifter directly if the shifter reloads on that edge.
  - Otherwise it goes to the holding register.
- The shifter reloads on an edge when either:
  - the FSM is in IDLE, or
  - the FSM leaves SHIFT or GAP and no gap cycles remain to be sent.
- Reload source priority: holding register first, then a word accepted on the same edge.
- When `hold_full` = 1, `din_ready` = 0, so a holding-register transfer and a new accept never occur on the same edge.
- FSM states:
  - IDLE: `out = IDLE_BIT`, `out_valid = 0`. Goes to SHIFT on any reload.
  - SHIFT: drives one bit per cycle for WIDTH cycles. On the last bit, `word_done` = 1. After the last bit:
    - GAP > 0: go to GAP.
    - GAP = 0 and a word is available: reload and stay in SHIFT.
    - GAP = 0 and no word available: go to IDLE.
  - GAP: `out = IDLE_BIT`, `out_valid = 0` for exactly GAP cycles. Then reload into SHIFT if a word is available, else go to IDLE.
- `busy = (state != IDLE) | hold_full`.
- A word is never dropped or duplicated. `din` is sampled only on the accept edge; later changes to `din` do not affect words already accepted.
- Reset while a word is in flight: both words are discarded and no partial-word completion occurs. `word_done` is not pulsed.

## Timing
- Reset values: `out = IDLE_BIT`, `out_valid = 0`, `word_done = 0`, `busy = 0`, `din_ready = 1`, FSM in IDLE, `hold_full = 0`.
- Latency: for a word accepted at edge k while IDLE, its first bit appears on `out` during the cycle after edge k. Bit i (0-based in send order) is valid in cycle k+1+i. The last bit and the `word_done` pulse are in cycle k+WIDTH.
- Back-to-back with GAP = 0: if the next word is held by the end of the last-bit cycle, its first bit follows with no bubble. Sustained throughput is one word per WIDTH cycles.
- With GAP = G: exactly G cycles with `out_valid` = 0 separate consecutive words.
- `din_ready` returns to 1 on the edge at which the holding register transfers into the shifter.
- Output timing: all outputs are registered except `din_ready`, which is a direct decode of `hold_full`; none depends combinationally on `din_valid`.

## Test plan
- Reset: hold `rst` = 0 while `din_valid` = 1 and `din` = 3'b111. Required: `out` = 0, `out_valid` = 0, `busy` = 0, and no word is accepted. After release, IDLE for 1 cycle, then the first accept.
- Single word, WIDTH = 2, MSB_FIRST = 1: send 2'b10. Required: `out` = 1 then 0 with `out_valid` = 1 in cycles k+1 and k+2, `word_done` in k+2, then IDLE. Detector sees "10".
- Back-to-back, WIDTH = 3, GAP = 0: send 3'b111 then 3'b110 with `din_valid` held high. Required: a continuous 6-cycle stream 1,1,1,1,1,0 and `word_done` twice, 3 cycles apart. `din_ready` is 0 from the second accept until the first word's last bit.
- Gap and LSB order, WIDTH = 2, GAP = 2, MSB_FIRST = 0: send 2'b10 then 2'b00. Required: stream 0,1,idle,idle,0,0, with `out_valid` low in exactly 2 cycles.
- Backpressure: keep `din_valid` = 1 with four words 01,00,10,11 at WIDTH = 2. Required: all four serialised in order, none lost or repeated. `din_ready` toggles as the holding register fills and drains.
- Reset mid-word: assert `rst` low after the 2nd bit of 3'b110 with a word held. Required: outputs return to reset values immediately, no `word_done`, and the held word is never emitted.
